// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: zero-latency next-PC lookup for IF, trained by the
// branch-resolving stage, with a saturating misprediction counter.
module branch_predictor #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2,
  parameter int MODE    = 1,
  parameter int CNTR_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              hit_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_next_pc_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_pred_taken_i,
  input  logic [ADDR_W-1:0] upd_pred_target_i,
  output logic              mispredict_o,
  output logic [CNTR_W-1:0] mispredict_cnt_o
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_WT   = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_WNT  = CNT_WT - CNT_W'(1);
  localparam logic [CNTR_W-1:0] MCNT_MAX = '1;

  logic              r_valid  [ENTRIES];
  logic [TAG_W-1:0]  r_tag    [ENTRIES];
  logic [CNT_W-1:0]  r_cnt    [ENTRIES];
  logic [ADDR_W-1:0] r_target [ENTRIES];
  logic [CNTR_W-1:0] r_misp_cnt;

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_upd_idx;
  logic [TAG_W-1:0]  w_upd_tag;
  logic              w_upd_hit;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [CNT_W-1:0]  w_cnt_dec;
  logic              w_unused;

  assign w_idx     = pc_i[IDX_W+1:2];
  assign w_tag     = pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign w_upd_idx = upd_pc_i[IDX_W+1:2];
  assign w_upd_tag = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  // PC bits outside the index/tag fields are intentionally ignored.
  assign w_unused  = ^{pc_i, upd_pc_i};

  // Lookup reads the registered table only, so a same-cycle update is not visible yet.
  always_comb begin
    hit_o          = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    pred_taken_o   = (MODE != 0) && hit_o && r_cnt[w_idx][CNT_W-1];
    pred_next_pc_o = pred_taken_o ? r_target[w_idx] : pc_i + ADDR_W'(4);
  end

  // upd_valid_i qualifies every upd_* input; there is no back-pressure, an update
  // presented in a cycle is always consumed at the following rising edge.
  always_comb begin
    w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    w_cnt_inc = (r_cnt[w_upd_idx] == CNT_MAX) ? CNT_MAX : r_cnt[w_upd_idx] + CNT_W'(1);
    w_cnt_dec = (r_cnt[w_upd_idx] == '0) ? '0 : r_cnt[w_upd_idx] - CNT_W'(1);
  end

  assign mispredict_o = upd_valid_i &&
                        ((upd_taken_i != upd_pred_taken_i) ||
                         (upd_taken_i && (upd_pred_target_i != upd_target_i)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_cnt[i]    <= CNT_WNT;
        r_target[i] <= '0;
      end
      r_misp_cnt <= '0;
    end else begin
      if (upd_valid_i) begin
        if (w_upd_hit) begin
          if (upd_taken_i) begin
            r_cnt[w_upd_idx]    <= w_cnt_inc;
            r_target[w_upd_idx] <= upd_target_i;
          end else begin
            r_cnt[w_upd_idx] <= w_cnt_dec;
          end
        end else if (upd_taken_i) begin
          // Taken miss evicts whatever occupies the slot and starts weakly taken.
          r_valid[w_upd_idx]  <= 1'b1;
          r_tag[w_upd_idx]    <= w_upd_tag;
          r_cnt[w_upd_idx]    <= CNT_WT;
          r_target[w_upd_idx] <= upd_target_i;
        end
      end
      if (mispredict_o && (r_misp_cnt != MCNT_MAX)) begin
        r_misp_cnt <= r_misp_cnt + CNTR_W'(1);
      end
    end
  end

  assign mispredict_cnt_o = r_misp_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: a dynamic instance and a static (MODE=0, CNTR_W=2)
// instance share stimulus; a behavioural table model feeds an expected-value queue.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;

  logic        d_hit, d_pt, d_misp;
  logic [31:0] d_next;
  logic [15:0] d_cnt;
  logic        s_hit, s_pt, s_misp;
  logic [31:0] s_next;
  logic [1:0]  s_cnt;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q[$];
  logic [63:0] exp_s_q[$];

  bit          m_valid  [64];
  int          m_tag    [64];
  int          m_cnt    [64];
  logic [31:0] m_target [64];
  int          m_dcnt;
  int          m_scnt;

  always #5 clk = ~clk;

  branch_predictor u_dyn (
    .clk_i(clk), .rst_i(rst), .pc_i(pc),
    .hit_o(d_hit), .pred_taken_o(d_pt), .pred_next_pc_o(d_next),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
    .upd_target_i(upd_target), .upd_pred_taken_i(upd_pred_taken),
    .upd_pred_target_i(upd_pred_target),
    .mispredict_o(d_misp), .mispredict_cnt_o(d_cnt)
  );

  branch_predictor #(.MODE(0), .CNTR_W(2)) u_sta (
    .clk_i(clk), .rst_i(rst), .pc_i(pc),
    .hit_o(s_hit), .pred_taken_o(s_pt), .pred_next_pc_o(s_next),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
    .upd_target_i(upd_target), .upd_pred_taken_i(upd_pred_taken),
    .upd_pred_target_i(upd_pred_target),
    .mispredict_o(s_misp), .mispredict_cnt_o(s_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i]  = 1'b0;
      m_tag[i]    = 0;
      m_cnt[i]    = 1;
      m_target[i] = 32'h0;
    end
    m_dcnt = 0;
    m_scnt = 0;
  endfunction

  function automatic void model_update(input logic [31:0] upc, input logic taken,
                                       input logic [31:0] tgt, input logic misp);
    int idx;
    int tg;
    idx = int'(upc[7:2]);
    tg  = int'(upc[15:8]);
    if (m_valid[idx] && m_tag[idx] == tg) begin
      if (taken) begin
        if (m_cnt[idx] < 3) m_cnt[idx] = m_cnt[idx] + 1;
        m_target[idx] = tgt;
      end else if (m_cnt[idx] > 0) begin
        m_cnt[idx] = m_cnt[idx] - 1;
      end
    end else if (taken) begin
      m_valid[idx]  = 1'b1;
      m_tag[idx]    = tg;
      m_cnt[idx]    = 2;
      m_target[idx] = tgt;
    end
    if (misp) begin
      if (m_dcnt < 65535) m_dcnt = m_dcnt + 1;
      if (m_scnt < 3) m_scnt = m_scnt + 1;
    end
  endfunction

  // One cycle: drive, predict from the model, compare at negedge, then advance the model.
  task automatic step(input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                      input logic ut, input logic [31:0] utgt, input logic upt,
                      input logic [31:0] uptgt, input logic rs = 1'b0);
    int          idx;
    logic        hit, pt, misp;
    logic [31:0] nxt;
    logic [63:0] e;
    rst = rs; pc = lpc; upd_valid = uv; upd_pc = upc; upd_taken = ut;
    upd_target = utgt; upd_pred_taken = upt; upd_pred_target = uptgt;
    idx  = int'(lpc[7:2]);
    hit  = m_valid[idx] && (m_tag[idx] == int'(lpc[15:8]));
    pt   = hit && (m_cnt[idx] >= 2);
    nxt  = pt ? m_target[idx] : lpc + 32'd4;
    misp = uv && ((ut != upt) || (ut && (uptgt != utgt)));
    exp_q.push_back({13'b0, hit, pt, nxt, misp, 16'(m_dcnt)});
    exp_s_q.push_back({13'b0, hit, 1'b0, lpc + 32'd4, misp, 16'(m_scnt)});
    @(negedge clk);
    e = exp_q.pop_front();
    check("dyn_hit",  64'(d_hit),  64'(e[50]));
    check("dyn_pt",   64'(d_pt),   64'(e[49]));
    check("dyn_next", 64'(d_next), 64'(e[48:17]));
    check("dyn_misp", 64'(d_misp), 64'(e[16]));
    check("dyn_cnt",  64'(d_cnt),  64'(e[15:0]));
    e = exp_s_q.pop_front();
    check("sta_hit",  64'(s_hit),  64'(e[50]));
    check("sta_pt",   64'(s_pt),   64'(e[49]));
    check("sta_next", 64'(s_next), 64'(e[48:17]));
    check("sta_misp", 64'(s_misp), 64'(e[16]));
    check("sta_cnt",  64'(s_cnt),  64'(e[15:0]));
    @(posedge clk);
    if (rs) model_reset();
    else if (uv) model_update(upc, ut, utgt, misp);
    #1;
  endtask

  task automatic idle(input logic [31:0] lpc);
    step(lpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1; upd_valid = 1'b0; pc = 32'h0; upd_pc = 32'h0; upd_taken = 1'b0;
    upd_target = 32'h0; upd_pred_taken = 1'b0; upd_pred_target = 32'h0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] rp, rt, ra;
    logic        rtk, rpt;
    do_reset();

    // Post-reset sweep: everything misses and falls through.
    for (int a = 0; a <= 'hFC; a += 4) idle(32'(a));
    idle(32'hFFFF_FFFC);

    // Loop branch training.
    step(32'h40, 1'b1, 32'h40, 1'b1, 32'h20, 1'b0, 32'h44);
    for (int k = 0; k < 3; k++) step(32'h40, 1'b1, 32'h40, 1'b1, 32'h20, 1'b1, 32'h20);
    idle(32'h40);
    step(32'h40, 1'b1, 32'h40, 1'b0, 32'h20, 1'b1, 32'h20);
    idle(32'h40);
    step(32'h40, 1'b1, 32'h40, 1'b0, 32'h20, 1'b1, 32'h20);
    idle(32'h40);

    // Target change on a hit entry.
    step(32'h40, 1'b1, 32'h40, 1'b1, 32'h20, 1'b0, 32'h44);
    step(32'h40, 1'b1, 32'h40, 1'b1, 32'h60, 1'b1, 32'h20);
    idle(32'h40);

    // Aliasing on index 0x10.
    step(32'h140, 1'b1, 32'h140, 1'b1, 32'h80, 1'b0, 32'h144);
    idle(32'h40);
    idle(32'h140);

    // Reset beats a simultaneous mispredicting update.
    step(32'h140, 1'b1, 32'h140, 1'b1, 32'h90, 1'b0, 32'h144, 1'b1);
    idle(32'h140);
    idle(32'h40);

    // Five mispredicts saturate the 2-bit counter.
    for (int k = 0; k < 5; k++) step(32'h80, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 32'h300);
    idle(32'h200);

    // Random traffic over a few indices and tags to stress aliasing and saturation.
    for (int k = 0; k < 300; k++) begin
      rp  = {16'($urandom), 8'($urandom_range(0, 2)), 6'($urandom_range(0, 3)), 2'b00};
      ra  = {16'($urandom), 8'($urandom_range(0, 2)), 6'($urandom_range(0, 3)), 2'b00};
      rt  = {$urandom_range(0, 255), 2'b00};
      rtk = 1'($urandom_range(0, 1));
      rpt = 1'($urandom_range(0, 1));
      step(ra, 1'($urandom_range(0, 3) != 0), rp, rtk, rt, rpt,
           ($urandom_range(0, 1) != 0) ? rt : rt + 32'd4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the 5-stage MIPS pipeline. It sits beside the PC in IF and has a direct-mapped table of saturating direction counters with tag and target fields. The IF stage gets a zero-latency prediction of the next PC. The stage that resolves branches updates the table and counts mispredictions. It generalises the current fixed "predict not-taken, flush on branch/jump" scheme in depth, counter width and mode.

## Interface
- ADDR_W, 32: PC / target width.
- ENTRIES, 64: table depth. Power of two, ≥2. IDX_W = log2(ENTRIES).
- TAG_W, 8: tag bits stored per entry. Requires IDX_W+TAG_W+2 ≤ ADDR_W.
- CNT_W, 2: direction counter width, ≥1.
- MODE, 1: 0 = static not-taken (table still trains, predictions forced not-taken); 1 = dynamic.
- CNTR_W, 16: width of the mispredict statistics counter.

- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- pc_i  in  ADDR_W  fetch PC to look up.
- hit_o  out  1  valid entry with matching tag for pc_i.
- pred_taken_o  out  1  predicted direction for pc_i.
- pred_next_pc_o  out  ADDR_W  predicted next fetch PC.
- upd_valid_i  in  1  a resolved branch is presented this cycle.
- upd_pc_i  in  ADDR_W  PC of the resolved branch.
- upd_taken_i  in  1  actual direction.
- upd_target_i  in  ADDR_W  actual taken target.
- upd_pred_taken_i  in  1  prediction made for this branch at fetch (carried down the pipe).
- upd_pred_target_i  in  ADDR_W  predicted next PC made at fetch.
- mispredict_o  out  1  combinational: the current update is a misprediction.
- mispredict_cnt_o  out  CNTR_W  number of mispredictions since reset, saturating.

## Operation
- Field split for any PC p:
  - index = p[IDX_W+1:2]
  - tag = p[IDX_W+TAG_W+1:IDX_W+2]
- Entry contents: valid, tag[TAG_W], cnt[CNT_W], target[ADDR_W].
- Lookup (combinational from table state):
  - hit_o = valid && tag match.
  - pred_taken_o = MODE && hit_o && cnt[CNT_W-1].
  - pred_next_pc_o = pred_taken_o ? target : pc_i+4. The add is modulo 2^ADDR_W.
- Update when upd_valid_i=1, applied to entry[index(upd_pc_i)]:
  - Hit, taken: cnt = min(cnt+1, 2^CNT_W-1); target = upd_target_i.
  - Hit, not taken: cnt = max(cnt-1, 0); target unchanged.
  - Miss, taken: allocate (replacing any occupant). valid=1, tag = tag(upd_pc_i), cnt = 2^(CNT_W-1) (weakly taken), target = upd_target_i.
  - Miss, not taken: no table change.
- mispredict_o = upd_valid_i && (upd_taken_i != upd_pred_taken_i || (upd_taken_i && upd_pred_target_i != upd_target_i)).
- mispredict_cnt_o increments by 1 when mispredict_o=1 and holds at 2^CNTR_W-1.
- Flushing the pipeline on mispredict_o is the CPU's job. The predictor only reports it.

## Timing
- Lookup latency: 0 cycles. Updates take effect at the clock edge.
- Same-cycle read/write of the same entry: lookup returns the pre-update contents. The new contents are visible on the next cycle.
- Back-to-back updates to the same entry on consecutive cycles are each applied cumulatively.
- Reset, on the first edge with rst_i=1:
  - every entry gets valid=0, tag=0, target=0, cnt = 2^(CNT_W-1)-1 (weakly not-taken);
  - mispredict_cnt_o = 0.
- Resulting output values:
  - Outputs follow immediately: hit_o=0, pred_taken_o=0, pred_next_pc_o = pc_i+4.
  - mispredict_o remains a function of its inputs.
- rst_i has priority over upd_valid_i in the same cycle. A reset mid-stream discards that update and does not count it.
- CNT_W=1: the counter is the last-outcome bit. Allocation sets cnt=1.

## Test plan
- Reset, then sweep pc_i = 0x0..0xFC: hit_o=0, pred_taken_o=0, pred_next_pc_o = pc_i+4 everywhere; mispredict_cnt_o=0.
- Train a loop branch:
  - First update: upd_pc=0x40, taken, target=0x20, pred_taken=0 → mispredict_o=1, count=1.
  - Next cycle, pc_i=0x40: hit_o=1, pred_taken_o=1, pred_next_pc_o=0x20.
  - Three more taken updates take cnt to 3 (saturated).
  - Then one not-taken update: cnt=2, still predicts taken.
  - Then a second not-taken update: cnt=1, predicts not-taken, pred_next_pc_o=0x44.
- Aliasing (ENTRIES=64):
  - Allocate 0x40 taken→0x20.
  - Send a taken update for 0x140 (same index, different tag), target 0x80.
  - pc_i=0x40 then shows hit_o=0. pc_i=0x140 shows hit_o=1, pred_next_pc_o=0x80.
- Target change: hit entry predicting 0x20 is updated taken with target 0x60 while upd_pred_target=0x20 → mispredict_o=1. The next lookup gives 0x60.
- Same-cycle read/write and reset priority:
  - Update 0x40 while pc_i=0x40: same cycle shows the old prediction, next cycle shows the new one.
  - rst_i=1 together with upd_valid_i=1: the table is cleared and the counter stays 0.
- MODE=0 with the loop training above: pred_taken_o=0 throughout; mispredict_cnt_o counts every taken update; hit_o still goes 1.
- CNTR_W=2 saturation: 5 mispredicts → mispredict_cnt_o=3.
